// File: rtl/lii_tx_arbiter.sv
// lii_tx_arbiter: round-robin merge of NSRC source streams onto one LII phy channel.
// Ports: aclk/arstn clock and async active-low reset; s_* per-source beats, tags and
// handshake (source i in slice i); lii_out_p0_* phy beat, tags and handshake.
module lii_tx_arbiter #(
    parameter int NSRC  = 4,
    parameter int PW    = 128,
    parameter int BURST = 4
) (
    input  logic              aclk,
    input  logic              arstn,
    input  logic [NSRC*PW-1:0] s_tdata,
    input  logic [NSRC-1:0]   s_tvalid,
    output logic [NSRC-1:0]   s_tready,
    input  logic [NSRC*8-1:0] s_src,
    input  logic [NSRC*8-1:0] s_dst,
    output logic [PW-1:0]     lii_out_p0_tdata,
    output logic              lii_out_p0_tvalid,
    input  logic              lii_out_p0_tready,
    output logic [7:0]        lii_out_p0_src,
    output logic [7:0]        lii_out_p0_dst
);
    localparam int GW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int BW = $clog2(BURST) + 1;
    localparam int EW = PW + 16;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d, last_gnt_q, last_gnt_d, pick;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [1:0]      occ_q, occ_d;
    logic [EW-1:0]   ent0_q, ent0_d, ent1_q, ent1_d, push_ent;
    logic            found, accept, pop;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= GW'(NSRC - 1);
            beat_cnt_q <= '0;
            occ_q      <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
            occ_q      <= occ_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

    // Rotating scan: first valid source after the last one served.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NSRC; k++) begin
            if (!found && s_tvalid[(int'(last_gnt_q) + k) % NSRC]) begin
                found = 1'b1;
                pick  = GW'((int'(last_gnt_q) + k) % NSRC);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d    = GRANT;
                gnt_d      = pick;
                beat_cnt_d = '0;
            end
        end else begin
            if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
            if ((accept && beat_cnt_q == BW'(BURST - 1)) || !s_tvalid[gnt_q]) begin
                state_d    = IDLE;
                last_gnt_d = gnt_q;
            end
        end
    end

    // Ready depends only on registered state, so phy tready never reaches the sources.
    always_comb begin
        s_tready = (state_q == GRANT && occ_q != 2'd2) ? NSRC'(1) << gnt_q : '0;
        accept   = s_tvalid[gnt_q] & s_tready[gnt_q];
        push_ent = {s_src[gnt_q*8 +: 8], s_dst[gnt_q*8 +: 8], s_tdata[gnt_q*PW +: PW]};
        pop      = lii_out_p0_tvalid & lii_out_p0_tready;
    end

    // ent0 is the head; a pop shifts ent1 forward, a push lands in the first free slot.
    always_comb begin
        occ_d  = occ_q + {1'b0, accept} - {1'b0, pop};
        ent0_d = pop ? ent1_q : ent0_q;
        ent1_d = ent1_q;
        if (accept) begin
            if (occ_q - {1'b0, pop} == 2'd0) ent0_d = push_ent;
            else ent1_d = push_ent;
        end
    end

    assign lii_out_p0_tvalid = (occ_q != 2'd0);
    assign lii_out_p0_tdata  = ent0_q[PW-1:0];
    assign lii_out_p0_dst    = ent0_q[PW +: 8];
    assign lii_out_p0_src    = ent0_q[PW+8 +: 8];
endmodule

// File: tb/tb_lii_tx_arbiter.sv
// tb_lii_tx_arbiter: scoreboard bench for lii_tx_arbiter.
module tb_lii_tx_arbiter;
    localparam int NSRC = 4, PW = 128, BURST = 4;

    typedef struct packed {
        logic [7:0]    src;
        logic [7:0]    dst;
        logic [PW-1:0] data;
    } beat_t;

    logic               aclk = 1'b0;
    logic               arstn;
    logic [NSRC*PW-1:0] s_tdata;
    logic [NSRC-1:0]    s_tvalid;
    logic [NSRC-1:0]    s_tready;
    logic [NSRC*8-1:0]  s_src;
    logic [NSRC*8-1:0]  s_dst;
    logic [PW-1:0]      lii_out_p0_tdata;
    logic               lii_out_p0_tvalid;
    logic               lii_out_p0_tready;
    logic [7:0]         lii_out_p0_src;
    logic [7:0]         lii_out_p0_dst;

    lii_tx_arbiter #(.NSRC(NSRC), .PW(PW), .BURST(BURST)) dut (
        .aclk(aclk), .arstn(arstn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_src(s_src), .s_dst(s_dst),
        .lii_out_p0_tdata(lii_out_p0_tdata), .lii_out_p0_tvalid(lii_out_p0_tvalid),
        .lii_out_p0_tready(lii_out_p0_tready),
        .lii_out_p0_src(lii_out_p0_src), .lii_out_p0_dst(lii_out_p0_dst)
    );

    always #5 aclk = ~aclk;

    beat_t           src_q[NSRC][$];
    beat_t           sb[$];
    int              out_cyc[$];
    logic [NSRC-1:0] en;
    logic [3:0]      bp_pat = 4'b1001;
    int              cyc, occ_m, n_vec, n_err, n_full, k0;
    bit              bp_mode, rdy_val, prev_stall;
    beat_t           prev_head;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] s, input logic [7:0] d, input logic [31:0] v);
        mk = {s, d, PW'(v)};
    endfunction

    function automatic beat_t head_out();
        head_out = {lii_out_p0_src, lii_out_p0_dst, lii_out_p0_tdata};
    endfunction

    task automatic drive();
        for (int i = 0; i < NSRC; i++) begin
            beat_t b;
            b = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            s_tvalid[i]          = en[i] && src_q[i].size() > 0;
            s_tdata[i*PW +: PW]  = b.data;
            s_src[i*8 +: 8]      = b.src;
            s_dst[i*8 +: 8]      = b.dst;
        end
        lii_out_p0_tready = bp_mode ? bp_pat[cyc % 4] : rdy_val;
    endtask

    task automatic push_beat(input int i, input beat_t b);
        src_q[i].push_back(b);
        sb.push_back(b);
    endtask

    task automatic tick();
        logic [NSRC-1:0] hs_in;
        logic            out_hs;
        @(negedge aclk);
        hs_in  = s_tvalid & s_tready;
        out_hs = lii_out_p0_tvalid & lii_out_p0_tready;
        if (bp_mode) begin
            if (occ_m == 2) begin
                n_full++;
                chk("rdy_full", 160'(s_tready), 160'(0));
            end
            if (prev_stall) begin
                chk("stall_vld", 160'(lii_out_p0_tvalid), 160'(1));
                chk("stall_head", 160'(head_out()), 160'(prev_head));
            end
            prev_stall = lii_out_p0_tvalid & !lii_out_p0_tready;
            prev_head  = head_out();
        end
        if (out_hs) begin
            if (sb.size() == 0) chk("sb_empty", 160'(0), 160'(1));
            else begin
                chk("beat", 160'(head_out()), 160'(sb.pop_front()));
                out_cyc.push_back(cyc);
            end
        end
        occ_m = occ_m + int'(|hs_in) - int'(out_hs);
        @(posedge aclk);
        cyc++;
        #1;
        for (int i = 0; i < NSRC; i++) if (hs_in[i]) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 160'(sb.size()), 160'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_err = 0; n_full = 0; cyc = 0; occ_m = 0;
        en = '0; rdy_val = 1'b1; bp_mode = 1'b0; prev_stall = 1'b0; prev_head = '0;
        s_tdata = '0; s_tvalid = '0; s_src = '0; s_dst = '0; lii_out_p0_tready = 1'b1;
        arstn = 1'b1;
        #1 arstn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_rdy", 160'(s_tready), 160'(0));
        chk("rst_vld", 160'(lii_out_p0_tvalid), 160'(0));
        chk("rst_data", 160'(lii_out_p0_tdata), 160'(0));
        chk("rst_src", 160'(lii_out_p0_src), 160'(0));
        chk("rst_dst", 160'(lii_out_p0_dst), 160'(0));
        arstn = 1'b1;
        tick();
        tick();
        chk("idle_vld", 160'(lii_out_p0_tvalid), 160'(0));

        // single source 2, three beats
        for (int n = 0; n < 3; n++) push_beat(2, mk(8'h02, 8'h10, 32'hA1 + n));
        en = 4'b0100;
        out_cyc.delete();
        drive();
        k0 = cyc;
        chk("idle_rdy", 160'(s_tready), 160'(0));
        tick();
        chk("grant_lat", 160'(s_tready), 160'(4'b0100));
        run(20);
        chk("data_lat", 160'(out_cyc[0]), 160'(k0 + 2));
        chk("consec1", 160'(out_cyc[1] - out_cyc[0]), 160'(1));
        chk("consec2", 160'(out_cyc[2] - out_cyc[1]), 160'(1));
        tick();
        chk("vld_end", 160'(lii_out_p0_tvalid), 160'(0));
        en = '0;

        // reset while the skid buffer is full
        for (int n = 0; n < 8; n++) push_beat(0, mk(8'h00, 8'h30, 32'hB0 + n));
        en = 4'b0001;
        rdy_val = 1'b0;
        drive();
        for (int n = 0; n < 10 && occ_m < 2; n++) tick();
        chk("occ_full", 160'(occ_m), 160'(2));
        #2 arstn = 1'b0;
        #1;
        chk("rst_mid_vld", 160'(lii_out_p0_tvalid), 160'(0));
        chk("rst_mid_rdy", 160'(s_tready), 160'(0));
        chk("rst_mid_data", 160'(lii_out_p0_tdata), 160'(0));
        for (int i = 0; i < NSRC; i++) src_q[i].delete();
        sb.delete();
        occ_m = 0;
        en = '0;
        tick();
        tick();
        arstn = 1'b1;
        for (int n = 0; n < 2; n++) push_beat(0, mk(8'h00, 8'h31, 32'hC0 + n));
        for (int n = 0; n < 2; n++) push_beat(3, mk(8'h03, 8'h33, 32'hC8 + n));
        en = 4'b1001;
        rdy_val = 1'b1;
        drive();
        run(30);

        // all sources contending
        for (int i = 0; i < NSRC; i++)
            for (int n = 0; n < 4; n++) push_beat(i, mk(8'(i), 8'(8'h20 + i), 32'(i * 16 + n)));
        en = 4'hF;
        out_cyc.delete();
        drive();
        run(40);
        chk("burst_back2back", 160'(out_cyc[1] - out_cyc[0]), 160'(1));
        chk("bubble", 160'(out_cyc[4] - out_cyc[3]), 160'(2));
        chk("span16", 160'(out_cyc[15] - out_cyc[0]), 160'(18));
        en = '0;

        // phy backpressure 1,0,0,1
        for (int n = 0; n < 8; n++) push_beat(0, mk(8'h00, 8'h40, 32'hD0 + n));
        en = 4'b0001;
        bp_mode = 1'b1;
        prev_stall = 1'b0;
        drive();
        run(80);
        chk("saw_full", 160'(n_full > 0), 160'(1));
        bp_mode = 1'b0;
        en = '0;
        drive();

        // source 1 drops valid after 2 beats, source 3 waiting
        for (int n = 0; n < 2; n++) push_beat(1, mk(8'h01, 8'h50, 32'hE0 + n));
        for (int n = 0; n < 2; n++) push_beat(3, mk(8'h03, 8'h53, 32'hE8 + n));
        en = 4'b1010;
        drive();
        run(30);
        en = '0;

        // per-beat tags
        push_beat(0, mk(8'h00, 8'h05, 32'hF0));
        push_beat(0, mk(8'h00, 8'h06, 32'hF1));
        push_beat(0, mk(8'h00, 8'h06, 32'hF2));
        en = 4'b0001;
        drive();
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
